adc_delay_calib: RTL and testbench
==================================

ADC_DELAY_CALIB -- requirements
Module: adc_delay_calib

Interface
REQ-001 The block SHALL have these parameters:
- DATA_WIDTH, 14, ADC sample width per channel.
- TAP_BITS, 5, IDELAY tap width (32 taps).
- PAT0, 14'h2AAA, first checkerboard test word.
- PAT1, 14'h1555, second checkerboard test word.
- SETTLE_CYCLES, 16, wait after each tap load.
- SAMPLE_COUNT, 256, valid samples checked per tap.
- TIMEOUT_CYCLES, 4096, maximum cycles spent in CHECK per tap.

REQ-002 The block SHALL have these ports:
- s_axi_aclk  in  1  sole clock; all inputs synchronous to it.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- cal_start  in  1  single-cycle calibration request.
- adc_valid  in  1  sample strobe.
- adc_data_a  in  DATA_WIDTH  channel A sample.
- adc_data_b  in  DATA_WIDTH  channel B sample.
- dly_ld  out  1  one-cycle IDELAY load strobe.
- dly_tap  out  TAP_BITS  tap value for the IDELAY.
- cal_busy  out  1  sweep in progress.
- cal_done  out  1  sticky success flag.
- cal_fail  out  1  sticky failure flag.
- best_tap  out  TAP_BITS  tap applied at completion.
- window_len  out  TAP_BITS+1  width of the widest passing window.

Function
REQ-003 States SHALL be IDLE, LOAD, SETTLE, CHECK, EVAL and APPLY; all outputs SHALL be registered.
REQ-004 In IDLE, cal_start=1 SHALL:
- clear cal_done, cal_fail, tap, run and best trackers;
- set cal_busy=1;
- transition to LOAD.
cal_start SHALL be ignored in every other state.
REQ-005 LOAD SHALL drive dly_tap=tap with dly_ld=1 for exactly that one cycle; the first dly_ld SHALL appear in the cycle after cal_start is sampled. Next state: SETTLE.
REQ-006 SETTLE SHALL last exactly SETTLE_CYCLES cycles, ignoring adc_valid, and then go to CHECK with the sample counter, cycle counter and error flag cleared.
REQ-007 In CHECK, each adc_valid sample SHALL fail (sticky error flag) if any of these hold:
- adc_data_a or adc_data_b is not PAT0 or PAT1;
- the sample equals the previous valid sample on the same channel.
The first sample in CHECK SHALL be tested for membership only.
REQ-008 CHECK SHALL exit to EVAL when either:
- SAMPLE_COUNT valid samples have been seen; or
- TIMEOUT_CYCLES cycles have elapsed, in which case the tap is marked failed regardless of samples.
REQ-009 EVAL (one cycle) SHALL update the trackers:
- pass: if run_len=0 then run_start=tap; run_len+=1.
- fail: run_len=0.
- if the new run_len > best_len (strict, so the earliest window wins ties), copy run_start/run_len into best_start/best_len.
REQ-010 From EVAL: if tap = 2^TAP_BITS-1, go to APPLY; otherwise tap+=1 and go to LOAD. Runs SHALL NOT wrap from the last tap back to tap 0.
REQ-011 APPLY with best_len>0 SHALL set:
- best_tap = best_start + floor((best_len-1)/2);
- window_len = best_len;
- dly_tap = best_tap with dly_ld=1 for one cycle;
- cal_done=1, cal_busy=0;
then go to IDLE.
REQ-012 APPLY with best_len=0 SHALL set:
- dly_tap=0, best_tap=0, window_len=0;
- dly_ld=1 for one cycle;
- cal_fail=1, cal_busy=0;
then go to IDLE.
REQ-013 cal_done and cal_fail SHALL be mutually exclusive and SHALL hold until the next accepted cal_start. dly_tap SHALL hold its last value between loads.
REQ-014 Tap arithmetic SHALL be unsigned; best_len SHALL count up to 2^TAP_BITS without overflow.

Reset
REQ-015 Reset assertion SHALL force IDLE immediately (including mid-sweep), with:
- dly_ld=0, dly_tap=0, cal_busy=0, cal_done=0, cal_fail=0;
- best_tap=0, window_len=0;
- all counters and trackers cleared.
No dly_ld SHALL be issued on reset release.

Verification
REQ-016 Passing taps 8..19, others corrupt -> best_tap=13, window_len=12, cal_done=1, final dly_ld with dly_tap=13.
REQ-017 Passing taps 2..5 and 20..23 -> tie resolved to the earliest window: best_tap=3, window_len=4.
REQ-018 No tap passes -> cal_fail=1, cal_done=0, dly_tap=0, window_len=0; exactly 33 dly_ld pulses in total.
REQ-019 Passing taps 26..31 -> best_tap=28, window_len=6; no wrap into tap 0 even if tap 0 passes.
REQ-020 adc_valid held low at tap 10, taps 4..20 otherwise pass -> tap 10 fails after 4096 cycles; windows 4..9 (len 6) and 11..20 (len 10) -> best_tap=15.
REQ-021 cal_start pulsed mid-sweep -> ignored; reset asserted during CHECK -> all outputs at reset values in the same cycle, no dly_ld after release until a new cal_start.

Source files
------------

// File: rtl/adc_delay_calib.sv
// ADC IDELAY calibration: sweeps every tap, checks a checkerboard pattern,
// then loads the centre of the widest passing window.
module adc_delay_calib #(
  parameter int                  DATA_WIDTH     = 14,
  parameter int                  TAP_BITS       = 5,
  parameter logic [DATA_WIDTH-1:0] PAT0         = 14'h2AAA,
  parameter logic [DATA_WIDTH-1:0] PAT1         = 14'h1555,
  parameter int                  SETTLE_CYCLES  = 16,
  parameter int                  SAMPLE_COUNT   = 256,
  parameter int                  TIMEOUT_CYCLES = 4096
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  cal_start,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data_a,
  input  logic [DATA_WIDTH-1:0] adc_data_b,
  output logic                  dly_ld,
  output logic [TAP_BITS-1:0]   dly_tap,
  output logic                  cal_busy,
  output logic                  cal_done,
  output logic                  cal_fail,
  output logic [TAP_BITS-1:0]   best_tap,
  output logic [TAP_BITS:0]     window_len
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(SAMPLE_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TAP_BITS-1:0] LAST = '1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, CHECK, EVAL, APPLY
  } state_t;

  state_t                state_q, state_d;
  logic [TAP_BITS-1:0]   tap_q, tap_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [CW-1:0]         samp_q, samp_d;
  logic [TW-1:0]         cyc_q, cyc_d;
  logic                  err_q, err_d;
  logic                  first_q, first_d;
  logic [DATA_WIDTH-1:0] prev_a_q, prev_a_d;
  logic [DATA_WIDTH-1:0] prev_b_q, prev_b_d;
  logic [TAP_BITS-1:0]   run_start_q, run_start_d;
  logic [TAP_BITS:0]     run_len_q, run_len_d;
  logic [TAP_BITS-1:0]   best_start_q, best_start_d;
  logic [TAP_BITS:0]     best_len_q, best_len_d;
  logic                  ld_q, ld_d;
  logic [TAP_BITS-1:0]   dtap_q, dtap_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [TAP_BITS-1:0]   btap_q, btap_d;
  logic [TAP_BITS:0]     wlen_q, wlen_d;

  logic                  bad_a, bad_b;
  logic [TAP_BITS:0]     ev_len;
  logic [TAP_BITS-1:0]   ev_start;
  logic [TAP_BITS-1:0]   centre;

  // Sample qualification and window arithmetic
  always_comb begin
    bad_a = (adc_data_a != PAT0) && (adc_data_a != PAT1);
    bad_b = (adc_data_b != PAT0) && (adc_data_b != PAT1);
    if (!first_q) begin
      bad_a = bad_a || (adc_data_a == prev_a_q);
      bad_b = bad_b || (adc_data_b == prev_b_q);
    end
    ev_len   = err_q ? '0 : run_len_q + 1'b1;
    ev_start = (!err_q && run_len_q == '0) ? tap_q : run_start_q;
    centre   = best_start_q +
               TAP_BITS'((best_len_q - 1'b1) >> 1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    settle_d     = settle_q;
    samp_d       = samp_q;
    cyc_d        = cyc_q;
    err_d        = err_q;
    first_d      = first_q;
    prev_a_d     = prev_a_q;
    prev_b_d     = prev_b_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    ld_d         = 1'b0;
    dtap_d       = dtap_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    btap_d       = btap_q;
    wlen_d       = wlen_q;
    unique case (state_q)
      IDLE: begin
        if (cal_start) begin
          done_d       = 1'b0;
          fail_d       = 1'b0;
          busy_d       = 1'b1;
          tap_d        = '0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          ld_d         = 1'b1;
          dtap_d       = '0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          samp_d  = '0;
          cyc_d   = '0;
          err_d   = 1'b0;
          first_d = 1'b1;
          state_d = CHECK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      CHECK: begin
        cyc_d = cyc_q + 1'b1;
        if (adc_valid) begin
          if (bad_a || bad_b) err_d = 1'b1;
          prev_a_d = adc_data_a;
          prev_b_d = adc_data_b;
          first_d  = 1'b0;
          samp_d   = samp_q + 1'b1;
        end
        if (adc_valid && samp_q == CW'(SAMPLE_COUNT - 1)) begin
          state_d = EVAL;
        end else if (cyc_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        run_len_d   = ev_len;
        run_start_d = ev_start;
        if (ev_len > best_len_q) begin
          best_len_d   = ev_len;
          best_start_d = ev_start;
        end
        if (tap_q == LAST) begin
          state_d = APPLY;
        end else begin
          tap_d   = tap_q + 1'b1;
          ld_d    = 1'b1;
          dtap_d  = tap_q + 1'b1;
          state_d = LOAD;
        end
      end
      APPLY: begin
        ld_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (best_len_q != '0) begin
          btap_d = centre;
          dtap_d = centre;
          wlen_d = best_len_q;
          done_d = 1'b1;
        end else begin
          btap_d = '0;
          dtap_d = '0;
          wlen_d = '0;
          fail_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      settle_q     <= '0;
      samp_q       <= '0;
      cyc_q        <= '0;
      err_q        <= 1'b0;
      first_q      <= 1'b0;
      prev_a_q     <= '0;
      prev_b_q     <= '0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      ld_q         <= 1'b0;
      dtap_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      btap_q       <= '0;
      wlen_q       <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      settle_q     <= settle_d;
      samp_q       <= samp_d;
      cyc_q        <= cyc_d;
      err_q        <= err_d;
      first_q      <= first_d;
      prev_a_q     <= prev_a_d;
      prev_b_q     <= prev_b_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      ld_q         <= ld_d;
      dtap_q       <= dtap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      btap_q       <= btap_d;
      wlen_q       <= wlen_d;
    end
  end

  assign dly_ld     = ld_q;
  assign dly_tap    = dtap_q;
  assign cal_busy   = busy_q;
  assign cal_done   = done_q;
  assign cal_fail   = fail_q;
  assign best_tap   = btap_q;
  assign window_len = wlen_q;

endmodule

// File: tb/tb_adc_delay_calib.sv
// Directed calibration sweeps with randomized sample traffic,
// checked against a window-search reference model.
module tb_adc_delay_calib;

  localparam logic [13:0] PAT0 = 14'h2AAA;
  localparam logic [13:0] PAT1 = 14'h1555;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cal_start;
  logic        adc_valid;
  logic [13:0] adc_a, adc_b;
  logic        dly_ld;
  logic [4:0]  dly_tap;
  logic        cal_busy, cal_done, cal_fail;
  logic [4:0]  best_tap;
  logic [5:0]  window_len;

  adc_delay_calib dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .cal_start     (cal_start),
    .adc_valid     (adc_valid),
    .adc_data_a    (adc_a),
    .adc_data_b    (adc_b),
    .dly_ld        (dly_ld),
    .dly_tap       (dly_tap),
    .cal_busy      (cal_busy),
    .cal_done      (cal_done),
    .cal_fail      (cal_fail),
    .best_tap      (best_tap),
    .window_len    (window_len)
  );

  initial forever #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          ld_log[$];
  logic [31:0] pass_mask = '0;
  int          to_tap = 99;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: largest all-passing window, earliest start on ties.
  task automatic model(input logic [31:0] m, input int tt,
                       output int bt, output int bl);
    bt = 0;
    bl = 0;
    for (int len = 32; len >= 1 && bl == 0; len--) begin
      for (int s = 0; s + len <= 32 && bl == 0; s++) begin
        bit ok = 1'b1;
        for (int k = s; k < s + len; k++)
          if (!m[k] || k == tt) ok = 1'b0;
        if (ok) begin
          bl = len;
          bt = s + (len - 1) / 2;
        end
      end
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // ADC emulation: data quality depends on the tap last loaded.
  initial begin : drv
    int cur = 0;
    int mode = 0;
    bit ph = 1'b0;
    adc_valid = 1'b0;
    adc_a = '0;
    adc_b = '0;
    forever begin
      @(negedge clk);
      if (dly_ld === 1'b1) begin
        ld_log.push_back(int'(dly_tap));
        cur = int'(dly_tap);
        mode = $urandom_range(2);
      end
      adc_valid = (cur == to_tap) ? 1'b0 :
                  ($urandom_range(15) != 0);
      adc_a = ph ? PAT0 : PAT1;
      adc_b = ph ? PAT1 : PAT0;
      if (!pass_mask[cur]) begin
        case (mode)
          0: adc_a = 14'($urandom);
          1: adc_a = PAT0;
          default: adc_b = 14'h0000;
        endcase
      end
      if (adc_valid) ph = ~ph;
    end
  end

  task automatic start_cal();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    chk("start_ld", dly_ld, 1);
    chk("start_tap", dly_tap, 0);
    chk("start_busy", cal_busy, 1);
    chk("start_done_clr", cal_done, 0);
    chk("start_fail_clr", cal_fail, 0);
  endtask

  task automatic sweep(input string nm, input logic [31:0] m,
                       input int tt, input bit mid);
    int et, el, base, cyc;
    bit ord;
    pass_mask = m;
    to_tap = tt;
    model(m, tt, et, el);
    repeat (3) @(negedge clk);
    base = ld_log.size();
    start_cal();
    cyc = 0;
    while (!(cal_done || cal_fail) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (mid && cyc == 3000) cal_start = 1'b1;
      if (mid && cyc == 3001) cal_start = 1'b0;
    end
    chk({nm, "_bounded"}, 32'(cyc < 20000), 1);
    chk({nm, "_final_ld"}, dly_ld, 1);
    chk({nm, "_dly_tap"}, dly_tap, et);
    chk({nm, "_best_tap"}, best_tap, et);
    chk({nm, "_window"}, window_len, el);
    chk({nm, "_done"}, cal_done, 32'(el > 0));
    chk({nm, "_fail"}, cal_fail, 32'(el == 0));
    chk({nm, "_busy"}, cal_busy, 0);
    @(negedge clk);
    chk({nm, "_ld_pulses"}, ld_log.size() - base, 33);
    ord = 1'b1;
    for (int i = 0; i < 32; i++)
      if (base + i >= ld_log.size() || ld_log[base + i] != i)
        ord = 1'b0;
    chk({nm, "_tap_order"}, 32'(ord), 1);
    chk({nm, "_ld_onecycle"}, dly_ld, 0);
    chk({nm, "_tap_hold"}, dly_tap, et);
  endtask

  initial begin : main
    int base, cyc;
    rst_n = 1'b0;
    cal_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ld", dly_ld, 0);
    chk("rst_tap", dly_tap, 0);
    chk("rst_busy", cal_busy, 0);
    chk("rst_done", cal_done, 0);
    chk("rst_fail", cal_fail, 0);
    chk("rst_best", best_tap, 0);
    chk("rst_wlen", window_len, 0);
    base = ld_log.size();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_release_no_ld", ld_log.size() - base, 0);

    sweep("win8_19", rng(8, 19), 99, 1'b1);
    sweep("tie", rng(2, 5) | rng(20, 23), 99, 1'b0);
    sweep("nopass", 32'h0, 99, 1'b0);
    sweep("top_nowrap", rng(26, 31) | 32'h1, 99, 1'b0);
    sweep("timeout", rng(4, 20), 10, 1'b0);
    sweep("random", $urandom, 99, 1'b0);

    pass_mask = rng(0, 31);
    to_tap = 99;
    repeat (3) @(negedge clk);
    base = ld_log.size();
    start_cal();
    cyc = 0;
    while (ld_log.size() - base < 4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reach_tap3", 32'(cyc < 2000), 1);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tap", dly_tap, 0);
    chk("async_rst_busy", cal_busy, 0);
    chk("async_rst_done", cal_done, 0);
    chk("async_rst_best", best_tap, 0);
    chk("async_rst_wlen", window_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = ld_log.size();
    repeat (50) @(negedge clk);
    chk("post_rst_no_ld", ld_log.size() - base, 0);
    chk("post_rst_idle", cal_busy, 0);
    start_cal();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
